// File: rtl/systolic_sequencer_pkg.sv
// Shared types and helpers for the systolic array feed sequencer.
//   state_e       : sequencer FSM state encoding
//   drain_cycles  : flush length after the last feed beat for an N x N array
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Longest skewer lane (2N) plus traversal of the array (2N-2).
  function automatic int unsigned drain_cycles(input int unsigned n);
    return 4 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_sequencer_seq_counter.sv
// Clear/enable up-counter with terminal-count flag.
//   clk, reset : clock, async active-low reset
//   clr_i      : synchronous clear (wins over enable)
//   en_i       : count enable; the count saturates at TERM and never wraps
//   count_o    : current count
//   tc_o       : high while count_o == TERM
module seq_counter #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned TERM  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc_o    = (count_q == WIDTH'(TERM));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Feed sequencer for an N x N systolic array: clears the accumulators, streams
// N operand rows into the input skewer, then flushes zeros until results settle.
//   clk, reset  : clock, async active-low reset
//   start       : launch one operation (IDLE only)
//   abort       : abandon the operation (any non-IDLE state)
//   in_valid    : lane_in holds the row for rd_addr this cycle
//   lane_in     : unskewed operand row
//   rd_addr     : row index requested from the operand buffer
//   lane_out    : row presented to the skewer
//   skew_enable : skewer shift enable
//   pe_clear    : accumulator clear
//   busy        : CLEAR through DRAIN
//   done        : one-cycle completion pulse
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for start
// CLEAR    | one cycle clearing the PE accumulators
// FEED     | streaming rows 0..N-1, stalls while in_valid low
// DRAIN    | shifting zeros through skewer and array
// DONE     | results final, single-cycle done pulse
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE = 2,
  parameter int unsigned DATA_SIZE   = 32
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      abort,
  input  logic                                      in_valid,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]     lane_in,
  output logic [$clog2(MATRIX_SIZE)-1:0]            rd_addr,
  output logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]     lane_out,
  output logic                                      skew_enable,
  output logic                                      pe_clear,
  output logic                                      busy,
  output logic                                      done
);

  localparam int unsigned BEAT_W  = $clog2(MATRIX_SIZE);
  localparam int unsigned DRAIN_N = drain_cycles(MATRIX_SIZE);
  localparam int unsigned DRAIN_W = $clog2(DRAIN_N);

  state_e state_q;
  state_e state_d;

  logic [BEAT_W-1:0]  beat_cnt;
  logic               beat_tc;
  logic               beat_clr;
  logic               beat_en;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               drain_tc;
  logic               drain_clr;
  logic               drain_en;
  logic               drain_last;

  // Counters sit at zero outside their own state, so both are zero on entry
  // to CLEAR; abort zeroes them on the same edge the FSM returns to IDLE.
  assign beat_clr   = (state_q != ST_FEED) || abort;
  assign beat_en    = (state_q == ST_FEED) && in_valid;
  assign drain_clr  = (state_q != ST_DRAIN) || abort;
  assign drain_en   = (state_q == ST_DRAIN) && !drain_tc;
  assign drain_last = (drain_cnt == DRAIN_W'(DRAIN_N - 1));

  seq_counter #(
    .WIDTH (BEAT_W),
    .TERM  (MATRIX_SIZE - 1)
  ) u_beat_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (beat_clr),
    .en_i    (beat_en),
    .count_o (beat_cnt),
    .tc_o    (beat_tc)
  );

  seq_counter #(
    .WIDTH (DRAIN_W),
    .TERM  (DRAIN_N - 1)
  ) u_drain_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (drain_clr),
    .en_i    (drain_en),
    .count_o (drain_cnt),
    .tc_o    (drain_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode only state, counters, and the data-path inputs, never
  // start or abort.
  always_comb begin
    state_d     = state_q;
    rd_addr     = '0;
    lane_out    = '0;
    skew_enable = 1'b0;
    pe_clear    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;

    if ((state_q != ST_IDLE) && abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start) state_d = ST_CLEAR;
        ST_CLEAR: state_d = ST_FEED;
        ST_FEED:  if (beat_tc && in_valid) state_d = ST_DRAIN;
        ST_DRAIN: if (drain_last) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end

    unique case (state_q)
      ST_CLEAR: begin
        pe_clear = 1'b1;
        busy     = 1'b1;
      end
      ST_FEED: begin
        busy        = 1'b1;
        rd_addr     = beat_cnt;
        lane_out    = lane_in;
        skew_enable = in_valid;
      end
      ST_DRAIN: begin
        busy        = 1'b1;
        skew_enable = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
module tb_systolic_sequencer;

  localparam int N = 2;
  localparam int D = 32;

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic                 abort;
  logic                 in_valid;
  logic [N-1:0][D-1:0]  lane_in;
  logic [0:0]           rd_addr;
  logic [N-1:0][D-1:0]  lane_out;
  logic                 skew_enable;
  logic                 pe_clear;
  logic                 busy;
  logic                 done;

  int total = 0;
  int bad   = 0;

  systolic_sequencer #(.MATRIX_SIZE(N), .DATA_SIZE(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .in_valid    (in_valid),
    .lane_in     (lane_in),
    .rd_addr     (rd_addr),
    .lane_out    (lane_out),
    .skew_enable (skew_enable),
    .pe_clear    (pe_clear),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] r;
    r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Rows 0xA/0xB then 0xC/0xD in cycles 2 and 3; distinctive junk elsewhere.
  function automatic logic [N-1:0][D-1:0] lane_pat(input int c);
    logic [N-1:0][D-1:0] v;
    if (c == 2)      v = {32'h0000_000B, 32'h0000_000A};
    else if (c == 3) v = {32'h0000_000D, 32'h0000_000C};
    else             v = {32'h5A00_0000 | 32'(c), 32'hA500_0000 | 32'(c)};
    return v;
  endfunction

  // Cycle 0 begins just after a rising edge with the DUT in IDLE.
  task automatic run_seq(input int tid, input int ncyc,
                         input logic [63:0] st_m, input logic [63:0] ab_m,
                         input logic [63:0] vl_m, input logic [63:0] pe_m,
                         input logic [63:0] sk_m, input logic [63:0] bz_m,
                         input logic [63:0] dn_m, input logic [63:0] rd_m,
                         input logic [63:0] ps_m);
    logic [N-1:0][D-1:0] exp_lane;
    for (int c = 0; c < ncyc; c++) begin
      start    = st_m[c];
      abort    = ab_m[c];
      in_valid = vl_m[c];
      lane_in  = lane_pat(c);
      exp_lane = ps_m[c] ? lane_pat(c) : '0;
      @(negedge clk);
      chk($sformatf("t%0d_c%0d_pe_clear", tid, c), 64'(pe_clear), 64'(pe_m[c]));
      chk($sformatf("t%0d_c%0d_skew", tid, c), 64'(skew_enable), 64'(sk_m[c]));
      chk($sformatf("t%0d_c%0d_busy", tid, c), 64'(busy), 64'(bz_m[c]));
      chk($sformatf("t%0d_c%0d_done", tid, c), 64'(done), 64'(dn_m[c]));
      chk($sformatf("t%0d_c%0d_rd_addr", tid, c), 64'(rd_addr), 64'(rd_m[c]));
      chk($sformatf("t%0d_c%0d_lane_out", tid, c), 64'(lane_out), 64'(exp_lane));
      @(posedge clk);
      #1;
    end
    start    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b1;
    abort    = 1'b0;
    in_valid = 1'b1;
    lane_in  = {32'h1111_1111, 32'h2222_2222};

    // Outputs must stay idle while reset is held, even with start high.
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_skew", 64'(skew_enable), 64'd0);
      chk("rst_pe_clear", 64'(pe_clear), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_rd_addr", 64'(rd_addr), 64'd0);
      chk("rst_lane_out", 64'(lane_out), 64'd0);
    end
    start = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    // T1: basic operation, in_valid tied high
    run_seq(1, 12, rng(0,0), '0, '1, rng(1,1), rng(2,9), rng(1,9),
            rng(10,10), rng(3,3), rng(2,3));

    // T2: single stall at cycle 3
    run_seq(2, 13, rng(0,0), '0, ~rng(3,3), rng(1,1), rng(2,2) | rng(4,10),
            rng(1,10), rng(11,11), rng(3,4), rng(2,4));

    // T3: abort in DRAIN at cycle 5, restart at cycle 7
    run_seq(3, 19, rng(0,0) | rng(7,7), rng(5,5), '1, rng(1,1) | rng(8,8),
            rng(2,5) | rng(9,16), rng(1,5) | rng(8,16), rng(17,17),
            rng(3,3) | rng(10,10), rng(2,3) | rng(9,10));

    // T4: start held high for 30 cycles -> back-to-back operations
    run_seq(4, 33, rng(0,29), '0, '1, rng(1,1) | rng(12,12) | rng(23,23),
            rng(2,9) | rng(13,20) | rng(24,31),
            rng(1,9) | rng(12,20) | rng(23,31),
            rng(10,10) | rng(21,21) | rng(32,32),
            rng(3,3) | rng(14,14) | rng(25,25),
            rng(2,3) | rng(13,14) | rng(24,25));

    // T5: abort on the last FEED beat beats the move to DRAIN
    run_seq(5, 8, rng(0,0), rng(3,3), '1, rng(1,1), rng(2,3), rng(1,3),
            '0, rng(3,3), rng(2,3));

    // T6: abort on the last DRAIN cycle beats the move to DONE
    run_seq(6, 12, rng(0,0), rng(9,9), '1, rng(1,1), rng(2,9), rng(1,9),
            '0, rng(3,3), rng(2,3));

    // T7: abort in IDLE ignored; start in FEED and in DONE not queued
    run_seq(7, 13, rng(0,0) | rng(5,5) | rng(10,10), rng(0,0), '1, rng(1,1),
            rng(2,9), rng(1,9), rng(10,10), rng(3,3), rng(2,3));

    // T8: abort in CLEAR
    run_seq(8, 5, rng(0,0), rng(1,1), '1, rng(1,1), '0, rng(1,1), '0, '0, '0);

    // T9: asynchronous reset mid-FEED
    in_valid = 1'b1;
    lane_in  = lane_pat(2);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("t9_feed_busy", 64'(busy), 64'd1);
    chk("t9_feed_skew", 64'(skew_enable), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("t9_async_busy", 64'(busy), 64'd0);
    chk("t9_async_skew", 64'(skew_enable), 64'd0);
    chk("t9_async_pe_clear", 64'(pe_clear), 64'd0);
    chk("t9_async_done", 64'(done), 64'd0);
    chk("t9_async_rd_addr", 64'(rd_addr), 64'd0);
    chk("t9_async_lane_out", 64'(lane_out), 64'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("t9_c%0d_no_done", c), 64'(done), 64'd0);
      chk($sformatf("t9_c%0d_idle_busy", c), 64'(busy), 64'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // T10: normal operation after reset recovery
    run_seq(10, 12, rng(0,0), '0, '1, rng(1,1), rng(2,9), rng(1,9),
            rng(10,10), rng(3,3), rng(2,3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
